key_cmd_decoder: RTL and testbench

- Parametrised successor to the single-purpose UART W/A/D movement decoder. Decodes received UART bytes into NUM_CH hold-timed command outputs, one per channel (e.g. jump/left/right/down).
- Echoes recognised keys back to the terminal through a small FIFO and a transmit sequencer.
- Sits between the uart instance and the game logic. It does not contain the UART.

---
 rtl/key_cmd_pkg.sv | 37 +++
 rtl/sync_fifo.sv | 66 ++++++
 rtl/key_cmd_decoder.sv | 166 ++++++++++++++++
 tb/tb_key_cmd_decoder.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_cmd_pkg.sv
// Shared constants, sequencer state type and game defaults for the key command decoder.
package key_cmd_pkg;

   localparam logic [7:0] AsciiA       = 8'h41;
   localparam logic [7:0] AsciiD       = 8'h44;
   localparam logic [7:0] AsciiS       = 8'h53;
   localparam logic [7:0] AsciiW       = 8'h57;
   localparam logic [7:0] AsciiLowerA  = 8'h61;
   localparam logic [7:0] AsciiLowerZ  = 8'h7A;
   localparam logic [7:0] AsciiCaseBit = 8'h20;

   localparam int unsigned DefNumCh = 4;
   localparam int unsigned DefCntW  = 27;

   // Channel order is ch3..ch0: down, right, left, jump.
   localparam logic [8*DefNumCh-1:0]       DefKeyCodes   = {AsciiS, AsciiD, AsciiA, AsciiW};
   localparam logic [DefCntW*DefNumCh-1:0] DefHoldCycles = {DefNumCh{27'd50_000_000}};
   localparam logic [DefNumCh-1:0]         DefExclMask   = 4'b0110;

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StWaitBusy,
      StWaitDone
   } tx_state_e;

   // Letters match in either case; every other code must match exactly.
   function automatic logic key_match(input logic [7:0] rx, input logic [7:0] code);
      logic [7:0] folded;
      folded = code | AsciiCaseBit;
      if (folded >= AsciiLowerA && folded <= AsciiLowerZ) begin
         return (rx | AsciiCaseBit) == folded;
      end
      return rx == code;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage; push into a full FIFO is accepted only
// when a pop frees a slot in the same cycle.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] dout
);

   localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AddrW:0] DepthCnt = DEPTH[AddrW:0];

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AddrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AddrW:0]   count_q, count_d;
   logic             wr_en, rd_en;

   assign full  = (count_q == DepthCnt);
   assign empty = (count_q == '0);
   assign dout  = mem_q[rd_ptr_q];
   assign rd_en = pop & ~empty;
   assign wr_en = push & (~full | rd_en);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + AddrW'(1);
      end
      if (rd_en) begin
         rd_ptr_d = rd_ptr_q + AddrW'(1);
      end
      if (wr_en && !rd_en) begin
         count_d = count_q + (AddrW + 1)'(1);
      end else if (rd_en && !wr_en) begin
         count_d = count_q - (AddrW + 1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

endmodule

// File: rtl/key_cmd_decoder.sv
// Turns received UART bytes into hold-timed per-channel command levels and echoes
// each recognised key back through a FIFO-fed transmit sequencer.
module key_cmd_decoder
   import key_cmd_pkg::*;
#(
   parameter int unsigned             NUM_CH        = DefNumCh,
   parameter int unsigned             CNT_W         = DefCntW,
   parameter logic [8*NUM_CH-1:0]     KEY_CODES     = DefKeyCodes,
   parameter logic [CNT_W*NUM_CH-1:0] HOLD_CYCLES   = DefHoldCycles,
   parameter bit                      RETRIG_EXTEND = 1'b0,
   parameter logic [NUM_CH-1:0]       EXCL_MASK     = DefExclMask,
   parameter int unsigned             FIFO_DEPTH    = 8,
   parameter int unsigned             BUSY_TIMEOUT  = 64
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cmd_enable,
   input  logic              received,
   input  logic [7:0]        rx_byte,
   input  logic              is_transmitting,
   output logic              transmit,
   output logic [7:0]        tx_byte,
   output logic [NUM_CH-1:0] cmd_active,
   output logic              echo_overflow
);

   localparam int unsigned TimerW = $clog2(BUSY_TIMEOUT + 1);

   logic [NUM_CH-1:0] raw_hit, hit, active_d, active_q;
   logic              excl_hit, found;

   // Only the lowest-indexed matching channel sees the key.
   always_comb begin
      raw_hit = '0;
      hit     = '0;
      found   = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         raw_hit[i] = received & cmd_enable & key_match(rx_byte, KEY_CODES[8*i +: 8]);
         if (raw_hit[i] && !found) begin
            hit[i] = 1'b1;
            found  = 1'b1;
         end
      end
   end

   assign excl_hit = |(hit & EXCL_MASK);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      localparam logic [CNT_W-1:0] Hold = HOLD_CYCLES[CNT_W*i +: CNT_W];

      logic [CNT_W-1:0] cnt_d, cnt_q;
      logic [CNT_W:0]   sum;

      always_comb begin
         sum   = {1'b0, cnt_q} + {1'b0, Hold};
         cnt_d = cnt_q;
         if (!cmd_enable) begin
            cnt_d = '0;
         end else if (hit[i]) begin
            if (RETRIG_EXTEND) begin
               cnt_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
            end else begin
               cnt_d = Hold;
            end
         end else if (EXCL_MASK[i] && excl_hit) begin
            cnt_d = '0;
         end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
         end
      end

      always_ff @(posedge clk) begin
         if (!reset_n) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_d;
         end
      end

      assign active_d[i] = (cnt_q != '0);
   end

   logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [7:0] fifo_dout;
   logic       echo_overflow_d, echo_overflow_q;

   assign fifo_push = |hit;

   sync_fifo #(
      .WIDTH(8),
      .DEPTH(FIFO_DEPTH)
   ) u_echo_fifo (
      .clk    (clk),
      .reset_n(reset_n),
      .push   (fifo_push),
      .din    (rx_byte),
      .pop    (fifo_pop),
      .full   (fifo_full),
      .empty  (fifo_empty),
      .dout   (fifo_dout)
   );

   assign echo_overflow_d = echo_overflow_q | (fifo_push & fifo_full & ~fifo_pop);

   tx_state_e         state_d, state_q;
   logic [7:0]        tx_byte_d, tx_byte_q;
   logic [TimerW-1:0] timer_d, timer_q;

   // tx_byte only changes when leaving idle, so it stays stable for the whole echo.
   always_comb begin
      state_d   = state_q;
      tx_byte_d = tx_byte_q;
      timer_d   = timer_q;
      fifo_pop  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!fifo_empty) begin
               tx_byte_d = fifo_dout;
               state_d   = StLoad;
            end
         end
         StLoad: begin
            timer_d = '0;
            state_d = StWaitBusy;
         end
         StWaitBusy: begin
            if (is_transmitting) begin
               state_d = StWaitDone;
            end else if (timer_q == TimerW'(BUSY_TIMEOUT - 1)) begin
               state_d = StIdle;
            end else begin
               timer_d = timer_q + TimerW'(1);
            end
         end
         StWaitDone: begin
            if (!is_transmitting) begin
               fifo_pop = 1'b1;
               state_d  = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q         <= StIdle;
         tx_byte_q       <= '0;
         timer_q         <= '0;
         active_q        <= '0;
         echo_overflow_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         tx_byte_q       <= tx_byte_d;
         timer_q         <= timer_d;
         active_q        <= active_d;
         echo_overflow_q <= echo_overflow_d;
      end
   end

   assign transmit      = (state_q == StLoad);
   assign tx_byte       = tx_byte_q;
   assign cmd_active    = active_q;
   assign echo_overflow = echo_overflow_q;

endmodule

// File: tb/tb_key_cmd_decoder.sv
// Directed bench for key_cmd_decoder: hold timing, exclusion, retrigger, echo FIFO,
// busy timeout, enable gating and reset.
module tb_key_cmd_decoder;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       cmd_enable = 1'b1;
   logic       received = 1'b0;
   logic [7:0] rx_byte = 8'h00;
   logic       uart_auto = 1'b0;
   logic       manual_busy = 1'b0;
   logic [2:0] busy_cnt = 3'd0;
   logic       is_transmitting;

   logic       tx_a, tx_b, tx_c;
   logic [7:0] txb_a, txb_b, txb_c;
   logic [3:0] act_a;
   logic [0:0] act_b, act_c;
   logic       ovf_a, ovf_b, ovf_c;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   logic [7:0] tx_log[$];
   int         tx_time[$];

   // Main instance: ch3 key '[' with zero hold, ch0 'W' hold 10, small FIFO and timeout.
   key_cmd_decoder #(
      .NUM_CH(4), .CNT_W(8),
      .KEY_CODES({8'h5B, 8'h44, 8'h41, 8'h57}),
      .HOLD_CYCLES({8'd0, 8'd8, 8'd6, 8'd10}),
      .RETRIG_EXTEND(1'b0), .EXCL_MASK(4'b0110), .FIFO_DEPTH(4), .BUSY_TIMEOUT(8)
   ) dut (
      .clk(clk), .reset_n(reset_n), .cmd_enable(cmd_enable), .received(received),
      .rx_byte(rx_byte), .is_transmitting(is_transmitting), .transmit(tx_a),
      .tx_byte(txb_a), .cmd_active(act_a), .echo_overflow(ovf_a)
   );

   key_cmd_decoder #(
      .NUM_CH(1), .CNT_W(8), .KEY_CODES(8'h57), .HOLD_CYCLES(8'd10),
      .RETRIG_EXTEND(1'b1), .EXCL_MASK(1'b0), .FIFO_DEPTH(8), .BUSY_TIMEOUT(64)
   ) dut_ext (
      .clk(clk), .reset_n(reset_n), .cmd_enable(cmd_enable), .received(received),
      .rx_byte(rx_byte), .is_transmitting(is_transmitting), .transmit(tx_b),
      .tx_byte(txb_b), .cmd_active(act_b), .echo_overflow(ovf_b)
   );

   key_cmd_decoder #(
      .NUM_CH(1), .CNT_W(4), .KEY_CODES(8'h57), .HOLD_CYCLES(4'd10),
      .RETRIG_EXTEND(1'b1), .EXCL_MASK(1'b0), .FIFO_DEPTH(8), .BUSY_TIMEOUT(64)
   ) dut_sat (
      .clk(clk), .reset_n(reset_n), .cmd_enable(cmd_enable), .received(received),
      .rx_byte(rx_byte), .is_transmitting(is_transmitting), .transmit(tx_c),
      .tx_byte(txb_c), .cmd_active(act_c), .echo_overflow(ovf_c)
   );

   always #5 clk = ~clk;

   // UART stand-in: busy for four cycles after each transmit request of the main instance.
   assign is_transmitting = uart_auto ? (busy_cnt != 3'd0) : manual_busy;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (tx_a) busy_cnt <= 3'd4;
      else if (busy_cnt != 3'd0) busy_cnt <= busy_cnt - 3'd1;
   end

   always @(negedge clk) begin
      if (tx_a) begin
         tx_log.push_back(txb_a);
         tx_time.push_back(cyc);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      rx_byte  = b;
      received = 1'b1;
      tick();
      received = 1'b0;
   endtask

   task automatic apply_reset();
      reset_n     = 1'b0;
      received    = 1'b0;
      cmd_enable  = 1'b1;
      uart_auto   = 1'b0;
      manual_busy = 1'b0;
      repeat (6) tick();
      reset_n = 1'b1;
      tx_log.delete();
      tx_time.delete();
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (6) tick();
      total++; if (act_a !== 4'h0) begin bad++; $display("FAIL reset_act: got %h want 0", act_a); end
      total++; if (tx_a !== 1'b0) begin bad++; $display("FAIL reset_tx: got %b want 0", tx_a); end
      total++; if (txb_a !== 8'h00) begin bad++; $display("FAIL reset_txb: got %h want 00", txb_a); end
      total++; if (ovf_a !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", ovf_a); end
      total++;
      if ({act_b, act_c, ovf_b, ovf_c, tx_b, tx_c, txb_b, txb_c} !== 22'h0) begin
         bad++; $display("FAIL reset_aux: got %b%b%b%b%b%b %h %h want all 0",
                         act_b, act_c, ovf_b, ovf_c, tx_b, tx_c, txb_b, txb_c);
      end
      reset_n = 1'b1;
   endtask

   task automatic test_single_press();
      apply_reset();
      uart_auto = 1'b1;
      send(8'h77);
      total++; if (act_a[0] !== 1'b0) begin bad++; $display("FAIL press_e0: got %b want 0", act_a[0]); end
      for (int k = 1; k <= 14; k++) begin
         tick();
         total++;
         if (act_a[0] !== (k <= 10)) begin
            bad++; $display("FAIL press_hold k=%0d: got %b want %b", k, act_a[0], (k <= 10));
         end
      end
      repeat (6) tick();
      total++;
      if (tx_log.size() != 1 || tx_log[0] !== 8'h77) begin
         bad++; $display("FAIL press_echo: got %0d bytes first %h want 1 byte 77",
                         tx_log.size(), (tx_log.size() > 0) ? tx_log[0] : 8'h00);
      end
   endtask

   task automatic test_exclusive();
      apply_reset();
      uart_auto = 1'b1;
      send(8'h41);
      for (int k = 1; k <= 4; k++) begin
         tick();
         total++; if (act_a[2:1] !== 2'b01) begin bad++; $display("FAIL excl_left k=%0d: got %b want 01", k, act_a[2:1]); end
      end
      send(8'h44);
      total++; if (act_a[2:1] !== 2'b01) begin bad++; $display("FAIL excl_edge: got %b want 01", act_a[2:1]); end
      for (int k = 1; k <= 10; k++) begin
         tick();
         total++;
         if (act_a[2:1] !== {(k <= 8), 1'b0}) begin
            bad++; $display("FAIL excl_right k=%0d: got %b want %b0", k, act_a[2:1], (k <= 8));
         end
      end
      repeat (10) tick();
      total++;
      if (tx_log.size() != 2 || tx_log[0] !== 8'h41 || tx_log[1] !== 8'h44) begin
         bad++; $display("FAIL excl_echo: got %0d bytes want 41,44", tx_log.size());
      end
   endtask

   // The loading edge holds the counter, so two presses give 2*HOLD+1 active cycles,
   // or fewer when the 4-bit counter saturates at 15.
   task automatic test_retrigger();
      apply_reset();
      send(8'h57);
      total++; if ({act_b, act_c} !== 2'b00) begin bad++; $display("FAIL retrig_e0: got %b%b want 00", act_b, act_c); end
      for (int k = 1; k <= 25; k++) begin
         if (k == 4) begin
            rx_byte  = 8'h57;
            received = 1'b1;
         end
         tick();
         received = 1'b0;
         total++;
         if (act_b[0] !== (k <= 21)) begin
            bad++; $display("FAIL retrig_ext k=%0d: got %b want %b", k, act_b[0], (k <= 21));
         end
         total++;
         if (act_c[0] !== (k <= 19)) begin
            bad++; $display("FAIL retrig_sat k=%0d: got %b want %b", k, act_c[0], (k <= 19));
         end
      end
   endtask

   task automatic test_overflow();
      logic [7:0] seq [6];
      logic [7:0] got;
      seq = '{8'h77, 8'h61, 8'h64, 8'h57, 8'h41, 8'h44};
      apply_reset();
      manual_busy = 1'b1;
      for (int i = 0; i < 6; i++) begin
         send(seq[i]);
         if (i == 3) begin
            total++; if (ovf_a !== 1'b0) begin bad++; $display("FAIL ovf_at_full: got %b want 0", ovf_a); end
         end
         if (i == 4) begin
            total++; if (ovf_a !== 1'b1) begin bad++; $display("FAIL ovf_drop: got %b want 1", ovf_a); end
         end
      end
      repeat (5) tick();
      total++; if (tx_log.size() != 1) begin bad++; $display("FAIL ovf_held: got %0d pulses want 1", tx_log.size()); end
      uart_auto = 1'b1;
      repeat (50) tick();
      total++; if (tx_log.size() != 4) begin bad++; $display("FAIL ovf_count: got %0d bytes want 4", tx_log.size()); end
      for (int i = 0; i < 4; i++) begin
         got = (i < tx_log.size()) ? tx_log[i] : 8'h00;
         total++; if (got !== seq[i]) begin bad++; $display("FAIL ovf_order i=%0d: got %h want %h", i, got, seq[i]); end
      end
      total++; if (ovf_a !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", ovf_a); end
   endtask

   task automatic test_busy_timeout();
      apply_reset();
      send(8'h61);
      send(8'h64);
      repeat (36) tick();
      total++; if (tx_log.size() != 4) begin bad++; $display("FAIL tmo_count: got %0d pulses want 4", tx_log.size()); end
      for (int i = 0; i < 4 && i < tx_log.size(); i++) begin
         total++; if (tx_log[i] !== 8'h61) begin bad++; $display("FAIL tmo_byte i=%0d: got %h want 61", i, tx_log[i]); end
      end
      for (int i = 1; i < 4 && i < tx_time.size(); i++) begin
         total++;
         if (tx_time[i] - tx_time[i-1] != 10) begin
            bad++; $display("FAIL tmo_gap i=%0d: got %0d want 10", i, tx_time[i] - tx_time[i-1]);
         end
      end
   endtask

   task automatic test_ignore();
      apply_reset();
      uart_auto = 1'b1;
      send(8'h78);
      send(8'h7B);
      repeat (12) tick();
      total++; if (act_a !== 4'h0) begin bad++; $display("FAIL ign_act: got %h want 0", act_a); end
      total++; if (tx_log.size() != 0) begin bad++; $display("FAIL ign_echo: got %0d bytes want 0", tx_log.size()); end
      send(8'h5B);
      for (int k = 1; k <= 12; k++) begin
         tick();
         total++; if (act_a !== 4'h0) begin bad++; $display("FAIL hold0_act k=%0d: got %h want 0", k, act_a); end
      end
      total++;
      if (tx_log.size() != 1 || tx_log[0] !== 8'h5B) begin
         bad++; $display("FAIL hold0_echo: got %0d bytes want 1 byte 5b", tx_log.size());
      end
      cmd_enable = 1'b0;
      send(8'h77);
      repeat (12) tick();
      total++; if (act_a !== 4'h0) begin bad++; $display("FAIL dis_act: got %h want 0", act_a); end
      total++; if (tx_log.size() != 1) begin bad++; $display("FAIL dis_echo: got %0d bytes want 1", tx_log.size()); end
      cmd_enable = 1'b1;
   endtask

   task automatic test_enable_and_reset();
      apply_reset();
      send(8'h44);
      tick();
      tick();
      total++; if (act_a[2] !== 1'b1) begin bad++; $display("FAIL en_pre: got %b want 1", act_a[2]); end
      cmd_enable = 1'b0;
      tick();
      total++; if (act_a[2] !== 1'b1) begin bad++; $display("FAIL en_lag: got %b want 1", act_a[2]); end
      tick();
      total++; if (act_a !== 4'h0) begin bad++; $display("FAIL en_clear: got %h want 0", act_a); end
      cmd_enable = 1'b1;
      send(8'h44);
      tick();
      total++; if (act_a[2] !== 1'b1) begin bad++; $display("FAIL rst_pre: got %b want 1", act_a[2]); end
      reset_n = 1'b0;
      tick();
      total++; if (act_a !== 4'h0) begin bad++; $display("FAIL rst_act: got %h want 0", act_a); end
      total++; if (tx_a !== 1'b0) begin bad++; $display("FAIL rst_tx: got %b want 0", tx_a); end
      total++; if (txb_a !== 8'h00) begin bad++; $display("FAIL rst_txb: got %h want 00", txb_a); end
      reset_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_single_press();
      test_exclusive();
      test_retrigger();
      test_overflow();
      test_busy_timeout();
      test_ignore();
      test_enable_and_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
